lvds_serializer_nlane: RTL

Parametrised N-lane, W:1 serializer for the LVDS transmit path, run entirely on the bit clock (one serial bit per `clk` cycle, SDR). It accepts one parallel word per lane per frame over a valid/ready handshake, buffers frames in a small FIFO, and shifts them out on all lanes in lock-step. It inserts an idle word on underrun and flags the event. The optional clock lane is generated in the same frame. The block sits between the pixel/packing logic and the output pads.

---
 rtl/lvds_serializer_nlane.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lvds_serializer_nlane.sv
// N-lane W:1 serializer on the bit clock: frame FIFO, idle-word insertion on underrun,
// lock-step shifting. Define SER_CLKLANE_EN to build the clock lane (out_clk_lane).
module lvds_serializer_nlane #(
  parameter int WIDTH = 7,
  parameter int LANES = 4,
  parameter int DEPTH = 2,
  parameter int LSB_FIRST = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0,
  parameter logic [WIDTH-1:0] CLK_PATTERN = 7'b1100011
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   underrun_clr,
  output logic [LANES-1:0]       out_lanes,
`ifdef SER_CLKLANE_EN
  output logic                   out_clk_lane,
`endif
  output logic                   frame_strobe,
  output logic                   underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (LSB_FIRST != 0) return w >> 1;
    else                return w << 1;
  endfunction

  function automatic logic serial_bit(input logic [WIDTH-1:0] w);
    if (LSB_FIRST != 0) return w[0];
    else                return w[WIDTH-1];
  endfunction

  logic [LANES*WIDTH-1:0]       mem [DEPTH];
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic [CW-1:0]                count;
  logic                         push, pop, fifo_empty;
  state_t                       state, state_nxt;
  logic [BW-1:0]                bit_cnt;
  logic                         boundary;
  logic                         load_idle, load_fifo, stop, ur_set;
  logic [LANES-1:0][WIDTH-1:0]  sr;
  logic [LANES-1:0][WIDTH-1:0]  idle_frame;

  // in_ready looks only at the registered count, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign in_ready   = (count != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);
  assign idle_frame = {LANES{IDLE_WORD}};
  assign boundary   = (state != S_IDLE) && (bit_cnt == BW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_PRIME;
      S_PRIME: if (boundary) begin
                 if (!enable)          state_nxt = S_IDLE;
                 else if (!fifo_empty) state_nxt = S_RUN;
               end
      S_RUN:   if (boundary && !enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_idle = 1'b0;
    load_fifo = 1'b0;
    pop       = 1'b0;
    stop      = 1'b0;
    ur_set    = 1'b0;
    case (state)
      S_IDLE: load_idle = enable;
      S_PRIME, S_RUN: begin
        if (boundary) begin
          if (!enable) begin
            stop = 1'b1;
          end else if (!fifo_empty) begin
            load_fifo = 1'b1;
            pop       = 1'b1;
          end else begin
            load_idle = 1'b1;
            ur_set    = (state == S_RUN);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              bit_cnt <= '0;
    else if (state == S_IDLE || boundary)  bit_cnt <= '0;
    else                                   bit_cnt <= bit_cnt + BW'(1);
  end

  // The serial pins are taken straight from the shift-register flops, so bit 0
  // of a frame is on the pins right after its load edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr           <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= load_idle || load_fifo;
      if (load_fifo)      sr <= mem[rd_ptr];
      else if (load_idle) sr <= idle_frame;
      else if (stop)      sr <= '0;
      else begin
        for (int k = 0; k < LANES; k++) sr[k] <= shift_word(sr[k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) out_lanes[k] = serial_bit(sr[k]);
  end

`ifdef SER_CLKLANE_EN
  logic [WIDTH-1:0] csr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        csr <= '0;
    else if (load_idle || load_fifo) csr <= CLK_PATTERN;
    else if (stop)                   csr <= '0;
    else                             csr <= shift_word(csr);
  end

  assign out_clk_lane = serial_bit(csr);
`endif

  // A set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              underrun <= 1'b0;
    else if (ur_set)       underrun <= 1'b1;
    else if (underrun_clr) underrun <= 1'b0;
  end

endmodule
